// File: rtl/id_ex_reg_if.sv
// Decode-to-execute bundle: the id_* side is driven by decode, the ex_* side by the ID/EX register.
// id_valid qualifies the decode slot; there is no back-pressure, so stalls arrive on the register's hold input.
interface id_ex_reg_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic            id_branch;
  logic            id_memread;
  logic            id_memtoreg;
  logic            id_memwrite;
  logic            id_aluSrc;
  logic            id_regwrite;
  logic [1:0]      id_Aluop;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;

  logic            ex_valid;
  logic            ex_branch;
  logic            ex_memread;
  logic            ex_memtoreg;
  logic            ex_memwrite;
  logic            ex_aluSrc;
  logic            ex_regwrite;
  logic [1:0]      ex_Aluop;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;

  // Decode side: produces the id_* bundle, observes the ex_* bundle.
  modport master (
    output id_valid, id_branch, id_memread, id_memtoreg, id_memwrite, id_aluSrc,
           id_regwrite, id_Aluop, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
    input  ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_aluSrc,
           ex_regwrite, ex_Aluop, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5
  );

  // Pipeline register side: consumes id_*, drives ex_*.
  modport slave (
    input  id_valid, id_branch, id_memread, id_memtoreg, id_memwrite, id_aluSrc,
           id_regwrite, id_Aluop, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
    output ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_aluSrc,
           ex_regwrite, ex_Aluop, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall (hold), bubble insertion (flush) and a saturating bubble counter.
// Update priority per edge: reset > flush > hold > load.
module id_ex_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  id_ex_reg_if.slave       bus,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'd0,
    MODE_HOLD  = 2'd1,
    MODE_FLUSH = 2'd2
  } mode_e;

  mode_e mode;

  logic            valid_q;
  logic            branch_q;
  logic            memread_q;
  logic            memtoreg_q;
  logic            memwrite_q;
  logic            alusrc_q;
  logic            regwrite_q;
  logic [1:0]      aluop_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;
  logic            funct7b5_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_sat_inc;

  always_comb begin
    mode = MODE_LOAD;
    if (flush)     mode = MODE_FLUSH;
    else if (hold) mode = MODE_HOLD;
  end

  assign cnt_sat_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Control bundle; a load with id_valid=0 becomes a bubble with all controls cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      branch_q   <= 1'b0;
      memread_q  <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      aluop_q    <= 2'b00;
    end else begin
      case (mode)
        MODE_FLUSH: begin
          valid_q    <= 1'b0;
          branch_q   <= 1'b0;
          memread_q  <= 1'b0;
          memtoreg_q <= 1'b0;
          memwrite_q <= 1'b0;
          alusrc_q   <= 1'b0;
          regwrite_q <= 1'b0;
          aluop_q    <= 2'b00;
        end
        MODE_LOAD: begin
          valid_q    <= bus.id_valid;
          branch_q   <= bus.id_valid & bus.id_branch;
          memread_q  <= bus.id_valid & bus.id_memread;
          memtoreg_q <= bus.id_valid & bus.id_memtoreg;
          memwrite_q <= bus.id_valid & bus.id_memwrite;
          alusrc_q   <= bus.id_valid & bus.id_aluSrc;
          regwrite_q <= bus.id_valid & bus.id_regwrite;
          aluop_q    <= bus.id_valid ? bus.id_Aluop : 2'b00;
        end
        default: ;
      endcase
    end
  end

  // Data and index fields load even for bubbles; a flush zeroes rd so forwarding never matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else begin
      case (mode)
        MODE_FLUSH: begin
          pc_q       <= '0;
          rs1_data_q <= '0;
          rs2_data_q <= '0;
          imm_q      <= '0;
          rs1_q      <= '0;
          rs2_q      <= '0;
          rd_q       <= '0;
          funct3_q   <= '0;
          funct7b5_q <= 1'b0;
        end
        MODE_LOAD: begin
          pc_q       <= bus.id_pc;
          rs1_data_q <= bus.id_rs1_data;
          rs2_data_q <= bus.id_rs2_data;
          imm_q      <= bus.id_imm;
          rs1_q      <= bus.id_rs1;
          rs2_q      <= bus.id_rs2;
          rd_q       <= bus.id_rd;
          funct3_q   <= bus.id_funct3;
          funct7b5_q <= bus.id_funct7b5;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (mode == MODE_FLUSH) begin
      cnt_q <= cnt_sat_inc;
    end else if (mode == MODE_LOAD && !bus.id_valid) begin
      cnt_q <= cnt_sat_inc;
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_branch   = branch_q;
  assign bus.ex_memread  = memread_q;
  assign bus.ex_memtoreg = memtoreg_q;
  assign bus.ex_memwrite = memwrite_q;
  assign bus.ex_aluSrc   = alusrc_q;
  assign bus.ex_regwrite = regwrite_q;
  assign bus.ex_Aluop    = aluop_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_rs1_data = rs1_data_q;
  assign bus.ex_rs2_data = rs2_data_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_rs1      = rs1_q;
  assign bus.ex_rs2      = rs2_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_funct3   = funct3_q;
  assign bus.ex_funct7b5 = funct7b5_q;
  assign bubble_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios with literal expectations plus randomized traffic
// against a record-level model of what the EX slot must contain after each edge.
module tb_id_ex_reg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic            valid;
    logic            branch;
    logic            memread;
    logic            memtoreg;
    logic            memwrite;
    logic            alusrc;
    logic            regwrite;
    logic [1:0]      aluop;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [CNT_W-1:0] cnt;
  } ex_t;
  localparam int EW = $bits(ex_t);

  logic clk;
  logic rst;
  logic hold;
  logic flush;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_reg_if #(.XLEN(XLEN)) bus ();

  id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .flush      (flush),
    .bus        (bus),
    .bubble_cnt (bubble_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];
  ex_t mdl;
  int  mdl_cnt;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ex_t dut_view();
    ex_t a;
    a.valid    = bus.ex_valid;
    a.branch   = bus.ex_branch;
    a.memread  = bus.ex_memread;
    a.memtoreg = bus.ex_memtoreg;
    a.memwrite = bus.ex_memwrite;
    a.alusrc   = bus.ex_aluSrc;
    a.regwrite = bus.ex_regwrite;
    a.aluop    = bus.ex_Aluop;
    a.pc       = bus.ex_pc;
    a.rs1_data = bus.ex_rs1_data;
    a.rs2_data = bus.ex_rs2_data;
    a.imm      = bus.ex_imm;
    a.rs1      = bus.ex_rs1;
    a.rs2      = bus.ex_rs2;
    a.rd       = bus.ex_rd;
    a.funct3   = bus.ex_funct3;
    a.funct7b5 = bus.ex_funct7b5;
    a.cnt      = bubble_cnt;
    return a;
  endfunction

  task automatic cmp_all(input string tag, input ex_t e);
    ex_t a;
    a = dut_view();
    if (a === e) begin
      n_cmp++;
    end else begin
      chk({tag, ".valid"},    32'(a.valid),    32'(e.valid));
      chk({tag, ".branch"},   32'(a.branch),   32'(e.branch));
      chk({tag, ".memread"},  32'(a.memread),  32'(e.memread));
      chk({tag, ".memtoreg"}, 32'(a.memtoreg), 32'(e.memtoreg));
      chk({tag, ".memwrite"}, 32'(a.memwrite), 32'(e.memwrite));
      chk({tag, ".aluSrc"},   32'(a.alusrc),   32'(e.alusrc));
      chk({tag, ".regwrite"}, 32'(a.regwrite), 32'(e.regwrite));
      chk({tag, ".Aluop"},    32'(a.aluop),    32'(e.aluop));
      chk({tag, ".pc"},       a.pc,            e.pc);
      chk({tag, ".rs1_data"}, a.rs1_data,      e.rs1_data);
      chk({tag, ".rs2_data"}, a.rs2_data,      e.rs2_data);
      chk({tag, ".imm"},      a.imm,           e.imm);
      chk({tag, ".rs1"},      32'(a.rs1),      32'(e.rs1));
      chk({tag, ".rs2"},      32'(a.rs2),      32'(e.rs2));
      chk({tag, ".rd"},       32'(a.rd),       32'(e.rd));
      chk({tag, ".funct3"},   32'(a.funct3),   32'(e.funct3));
      chk({tag, ".funct7b5"}, 32'(a.funct7b5), 32'(e.funct7b5));
      chk({tag, ".bubble_cnt"}, 32'(a.cnt),    32'(e.cnt));
    end
  endtask

  // Single compare process: one expected EX record per clock edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) cmp_all("edge", ex_t'(exp_q.pop_front()));
  end

  // ---------------- model + driver tasks ----------------
  function automatic int bump(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  // Advance one edge: the EX record becomes whatever the sampled decode slot dictates.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      mdl = '0;
      mdl_cnt = 0;
    end else if (flush) begin
      mdl = '0;
      mdl_cnt = bump(mdl_cnt);
    end else if (!hold) begin
      mdl.valid    = bus.id_valid;
      mdl.branch   = bus.id_valid ? bus.id_branch   : 1'b0;
      mdl.memread  = bus.id_valid ? bus.id_memread  : 1'b0;
      mdl.memtoreg = bus.id_valid ? bus.id_memtoreg : 1'b0;
      mdl.memwrite = bus.id_valid ? bus.id_memwrite : 1'b0;
      mdl.alusrc   = bus.id_valid ? bus.id_aluSrc   : 1'b0;
      mdl.regwrite = bus.id_valid ? bus.id_regwrite : 1'b0;
      mdl.aluop    = bus.id_valid ? bus.id_Aluop    : 2'b00;
      mdl.pc       = bus.id_pc;
      mdl.rs1_data = bus.id_rs1_data;
      mdl.rs2_data = bus.id_rs2_data;
      mdl.imm      = bus.id_imm;
      mdl.rs1      = bus.id_rs1;
      mdl.rs2      = bus.id_rs2;
      mdl.rd       = bus.id_rd;
      mdl.funct3   = bus.id_funct3;
      mdl.funct7b5 = bus.id_funct7b5;
      if (!bus.id_valid) mdl_cnt = bump(mdl_cnt);
    end
    mdl.cnt = CNT_W'(mdl_cnt);
    exp_q.push_back(mdl);
    @(negedge clk);
  endtask

  task automatic clear_in();
    hold = 0; flush = 0;
    bus.id_valid = 0; bus.id_branch = 0; bus.id_memread = 0; bus.id_memtoreg = 0;
    bus.id_memwrite = 0; bus.id_aluSrc = 0; bus.id_regwrite = 0; bus.id_Aluop = 2'b00;
    bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0; bus.id_funct3 = '0; bus.id_funct7b5 = 0;
  endtask

  task automatic randomize_in();
    bus.id_valid    = ($urandom_range(0, 3) != 0);
    bus.id_branch   = 1'($urandom_range(0, 1));
    bus.id_memread  = 1'($urandom_range(0, 1));
    bus.id_memtoreg = 1'($urandom_range(0, 1));
    bus.id_memwrite = 1'($urandom_range(0, 1));
    bus.id_aluSrc   = 1'($urandom_range(0, 1));
    bus.id_regwrite = 1'($urandom_range(0, 1));
    bus.id_Aluop    = 2'($urandom_range(0, 3));
    bus.id_pc       = $urandom;
    bus.id_rs1_data = $urandom;
    bus.id_rs2_data = $urandom;
    bus.id_imm      = $urandom;
    bus.id_rs1      = 5'($urandom_range(0, 31));
    bus.id_rs2      = 5'($urandom_range(0, 31));
    bus.id_rd       = 5'($urandom_range(0, 31));
    bus.id_funct3   = 3'($urandom_range(0, 7));
    bus.id_funct7b5 = 1'($urandom_range(0, 1));
    hold  = ($urandom_range(0, 3) == 0);
    flush = ($urandom_range(0, 7) == 0);
  endtask

  // Called at a falling edge: reset lands mid-cycle and must clear outputs before the next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    mdl = '0;
    mdl_cnt = 0;
    cmp_all("async_rst", mdl);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mdl = '0;
    mdl_cnt = 0;
    rst = 1'b1;
    clear_in();
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_cnt", 32'(bubble_cnt), 32'd0);
    chk("reset_valid", 32'(bus.ex_valid), 32'd0);

    // R-type load
    bus.id_valid = 1; bus.id_regwrite = 1; bus.id_Aluop = 2'b10; bus.id_rd = 5'd5;
    bus.id_rs1_data = 32'h11; bus.id_rs2_data = 32'h22;
    cycle();
    chk("rtype_regwrite", 32'(bus.ex_regwrite), 32'd1);
    chk("rtype_aluop", 32'(bus.ex_Aluop), 32'd2);
    chk("rtype_rd", 32'(bus.ex_rd), 32'd5);
    chk("rtype_rs1_data", bus.ex_rs1_data, 32'h11);
    chk("rtype_rs2_data", bus.ex_rs2_data, 32'h22);
    chk("rtype_cnt", 32'(bubble_cnt), 32'd0);

    // lw load, then three held cycles with different decode contents
    clear_in();
    bus.id_valid = 1; bus.id_memread = 1; bus.id_memtoreg = 1; bus.id_regwrite = 1;
    bus.id_aluSrc = 1; bus.id_imm = 32'h8; bus.id_rd = 5'd7;
    cycle();
    hold = 1;
    bus.id_imm = 32'h44; bus.id_memread = 0; bus.id_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_imm", bus.ex_imm, 32'h8);
      chk("hold_memread", 32'(bus.ex_memread), 32'd1);
      chk("hold_rd", 32'(bus.ex_rd), 32'd7);
    end
    hold = 0;
    cycle();
    chk("release_imm", bus.ex_imm, 32'h44);
    chk("release_rd", 32'(bus.ex_rd), 32'd9);

    // beq, then flush and hold on the same edge
    clear_in();
    bus.id_valid = 1; bus.id_branch = 1; bus.id_Aluop = 2'b01; bus.id_rd = 5'd3;
    cycle();
    chk("beq_branch", 32'(bus.ex_branch), 32'd1);
    flush = 1; hold = 1;
    cycle();
    chk("flushhold_valid", 32'(bus.ex_valid), 32'd0);
    chk("flushhold_branch", 32'(bus.ex_branch), 32'd0);
    chk("flushhold_rd", 32'(bus.ex_rd), 32'd0);
    chk("flushhold_cnt", 32'(bubble_cnt), 32'd1);

    // invalid slot with stray store/writeback controls
    clear_in();
    bus.id_valid = 0; bus.id_memwrite = 1; bus.id_regwrite = 1; bus.id_pc = 32'h100;
    cycle();
    chk("bubble_memwrite", 32'(bus.ex_memwrite), 32'd0);
    chk("bubble_regwrite", 32'(bus.ex_regwrite), 32'd0);
    chk("bubble_pc", bus.ex_pc, 32'h100);
    chk("bubble_cnt", 32'(bubble_cnt), 32'd2);

    // saturation
    clear_in();
    flush = 1;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_cnt", 32'(bubble_cnt), 32'd15);
    cycle();
    chk("sat_cnt_stay", 32'(bubble_cnt), 32'd15);

    // async reset with nonzero contents
    clear_in();
    bus.id_valid = 1; bus.id_regwrite = 1; bus.id_rd = 5'd12; bus.id_pc = 32'hdead_beef;
    cycle();
    async_reset();
    chk("postrst_cnt", 32'(bubble_cnt), 32'd0);

    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      randomize_in();
      if ($urandom_range(0, 63) == 0) async_reset();
      else cycle();
    end

    clear_in();
    cycle();
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
